// File: rtl/mod_audio_adc.sv
// mod_audio_adc: I2S / left-justified receiver for the WM8731 ADC path, oversampled in the i_clk domain
// Ports: i_clk/i_rst system clock and async active-high reset;
//        i_aud_bclk/i_aud_adclrck/i_aud_adcdat raw codec serial inputs (asynchronous);
//        i_enable capture enable; o_left/o_right/o_valid/i_ready single-entry stereo output register;
//        o_overrun sticky frame-lost flag, i_clear_overrun clears it.
module mod_audio_adc #(
   parameter int SAMPLE_WIDTH = 16,
   parameter bit I2S_DELAY    = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_aud_bclk,
   input  logic                    i_aud_adclrck,
   input  logic                    i_aud_adcdat,
   input  logic                    i_enable,
   output logic [SAMPLE_WIDTH-1:0] o_left,
   output logic [SAMPLE_WIDTH-1:0] o_right,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_overrun,
   input  logic                    i_clear_overrun
);
   localparam int CW = $clog2(SAMPLE_WIDTH + 1);
   typedef enum logic [1:0] {ALIGN, SKIP, SHIFT, HOLD} state_t;
   state_t state, state_n;
   logic [1:0] bclk_s, lr_s, dat_s;
   logic bclk_h, lr_h, bclk_rise, lr_edge, lr_fall;
   logic [SAMPLE_WIDTH-1:0] shreg, left_hold, right_word, fin_word;
   logic [CW-1:0] bit_cnt;
   logic chan, emit_pend, fin, start, shift_en;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         bclk_s <= '0;
         lr_s   <= '0;
         dat_s  <= '0;
         bclk_h <= 1'b0;
         lr_h   <= 1'b0;
      end else begin
         bclk_s <= {bclk_s[0], i_aud_bclk};
         lr_s   <= {lr_s[0], i_aud_adclrck};
         dat_s  <= {dat_s[0], i_aud_adcdat};
         bclk_h <= bclk_s[1];
         lr_h   <= lr_s[1];
      end
   assign bclk_rise = bclk_s[1] & ~bclk_h;
   assign lr_edge   = lr_s[1] ^ lr_h;
   assign lr_fall   = lr_edge & ~lr_s[1];
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) state <= ALIGN;
      else       state <= state_n;
   // An LRCK edge always wins over a coincident BCLK rise: the old word is finalized and the
   // rise is then treated as the first bit slot of the new word (delay slot, or MSB when no delay).
   always_comb begin
      state_n  = state;
      fin      = 1'b0;
      start    = 1'b0;
      shift_en = 1'b0;
      fin_word = shreg << (CW'(SAMPLE_WIDTH) - bit_cnt);
      if (!i_enable) state_n = ALIGN;
      else if (state == ALIGN ? lr_fall : lr_edge) begin
         fin      = state inside {SKIP, SHIFT};
         start    = 1'b1;
         state_n  = (I2S_DELAY && !bclk_rise) ? SKIP : SHIFT;
         shift_en = !I2S_DELAY && bclk_rise;
      end else if (bclk_rise) begin
         if (state == SKIP) state_n = SHIFT;
         else if (state == SHIFT) begin
            shift_en = 1'b1;
            if (bit_cnt == CW'(SAMPLE_WIDTH - 1)) begin
               fin      = 1'b1;
               fin_word = {shreg[SAMPLE_WIDTH-2:0], dat_s[1]};
               state_n  = HOLD;
            end
         end
      end
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         chan       <= 1'b0;
         left_hold  <= '0;
         right_word <= '0;
         emit_pend  <= 1'b0;
      end else begin
         if (start) begin
            chan    <= lr_s[1];
            shreg   <= shift_en ? SAMPLE_WIDTH'(dat_s[1]) : '0;
            bit_cnt <= shift_en ? CW'(1) : '0;
         end else if (shift_en) begin
            shreg   <= {shreg[SAMPLE_WIDTH-2:0], dat_s[1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (fin && !chan) left_hold <= fin_word;
         if (fin && chan) right_word <= fin_word;
         emit_pend <= fin & chan;
      end
   // A new frame always lands in the output register; if the previous one was still unconsumed it is lost.
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         o_left    <= '0;
         o_right   <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (emit_pend) begin
            o_left  <= left_hold;
            o_right <= right_word;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) o_valid <= 1'b0;
         if (emit_pend && o_valid && !i_ready) o_overrun <= 1'b1;
         else if (i_clear_overrun) o_overrun <= 1'b0;
      end
endmodule

// File: tb/tb_mod_audio_adc.sv
// tb_mod_audio_adc: directed self-checking bench for mod_audio_adc (I2S and left-justified instances)
module tb_mod_audio_adc;
   logic clk = 0, rst = 1, bclk = 0, lrck = 1, dat = 0, en = 1, rdy = 1, clr = 0;
   logic [15:0] l1, r1, l0, r0;
   logic v1, v0, ov1, ov0;
   int cyc = 0, checks = 0, failures = 0, dly = 1, last_rise = 0, vrise = -1;
   logic vp = 0;
   logic [31:0] q1[$], q0[$];
   typedef struct {
      logic [31:0] ld;
      int lb, lp;
      logic [31:0] rd;
      int rb, rp;
      logic [31:0] exp;
   } vec_t;
   vec_t tv[6];
   always #5 clk = ~clk;
   mod_audio_adc #(.SAMPLE_WIDTH(16), .I2S_DELAY(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_aud_bclk(bclk), .i_aud_adclrck(lrck), .i_aud_adcdat(dat),
      .i_enable(en), .o_left(l1), .o_right(r1), .o_valid(v1), .i_ready(rdy),
      .o_overrun(ov1), .i_clear_overrun(clr));
   mod_audio_adc #(.SAMPLE_WIDTH(16), .I2S_DELAY(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_aud_bclk(bclk), .i_aud_adclrck(lrck), .i_aud_adcdat(dat),
      .i_enable(en), .o_left(l0), .o_right(r0), .o_valid(v0), .i_ready(rdy),
      .o_overrun(ov0), .i_clear_overrun(clr));
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (v1 && !vp) vrise = cyc;
      vp = v1;
      if (v1 && rdy) q1.push_back({l1, r1});
      if (v0 && rdy) q0.push_back({l0, r0});
   end
   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         tick(8);
         bclk = 1;
         tick(8);
         bclk = 0;
      end
   endtask
   // One LRCK half: optional delay slot, nb data bits MSB first, pad filler bits; filler is 1 so
   // any wrongly captured slot corrupts the result.
   task automatic send_word(input logic ch, input logic [31:0] d, input int nb, input int pad);
      for (int i = 0; i < dly + nb + pad; i++) begin
         int j;
         j = i - dly;
         if (i == 0) lrck = ch;
         dat = (j >= 0 && j < nb) ? d[nb-1-j] : 1'b1;
         tick(8);
         bclk = 1;
         if (ch && j == ((nb < 16) ? nb : 16) - 1) last_rise = cyc;
         tick(8);
         bclk = 0;
      end
   endtask
   task automatic send_frame(input logic [31:0] ld, input int lb, input int lp,
                             input logic [31:0] rd, input int rb, input int rp);
      send_word(1'b0, ld, lb, lp);
      send_word(1'b1, rd, rb, rp);
   endtask
   task automatic chk_frame(input string name, input logic [31:0] exp);
      logic [31:0] got;
      got = (q1.size() > 0) ? q1[0] : 32'hxxxxxxxx;
      chk({name, "_count"}, 32'(q1.size()), 32'd1);
      chk({name, "_data"}, got, exp);
      q1.delete();
   endtask
   initial begin
      tv[0] = '{32'hA5C3,   16, 0, 32'h1234, 16, 0, 32'hA5C3_1234};
      tv[1] = '{32'hABCDFF, 24, 0, 32'h5A5A, 16, 8, 32'hABCD_5A5A};
      tv[2] = '{32'hABC,    12, 0, 32'h0F0F, 16, 0, 32'hABC0_0F0F};
      tv[3] = '{32'h8000,   16, 0, 32'h7FFF, 16, 0, 32'h8000_7FFF};
      tv[4] = '{32'hFFFF,   16, 0, 32'h0001, 16, 0, 32'hFFFF_0001};
      tv[5] = '{32'h0000,   16, 0, 32'hFFFF, 16, 0, 32'h0000_FFFF};
      tick(5);
      chk("rst_out1", {l1, r1}, 32'h0);
      chk("rst_flags1", {30'b0, v1, ov1}, 32'h0);
      chk("rst_out0", {l0, r0}, 32'h0);
      chk("rst_flags0", {30'b0, v0, ov0}, 32'h0);
      rst = 0;
      idle(4);
      for (int i = 0; i < 6; i++) begin
         int d;
         q1.delete();
         vrise = -1;
         send_frame(tv[i].ld, tv[i].lb, tv[i].lp, tv[i].rd, tv[i].rb, tv[i].rp);
         tick(2);
         chk_frame($sformatf("vec%0d", i), tv[i].exp);
         d = vrise - last_rise;
         checks++;
         if (d < 1 || d > 5) begin
            failures++;
            $display("FAIL vec%0d_latency got=%0d cycles expected=1..5", i, d);
         end
      end
      q1.delete();
      send_word(1'b0, 32'h1357, 16, 0);
      fork
         send_word(1'b1, 32'h2468, 16, 0);
         begin
            tick(40);
            rst = 1;
            tick(3);
            rst = 0;
         end
      join
      tick(2);
      chk("rstmid_count", 32'(q1.size()), 32'd0);
      chk("rstmid_valid", 32'(v1), 32'd0);
      send_frame(32'h0FF0, 16, 0, 32'hF00F, 16, 0);
      tick(2);
      chk_frame("rstmid_frame", 32'h0FF0_F00F);
      rdy = 0;
      send_frame(32'h1111, 16, 0, 32'h2222, 16, 0);
      tick(2);
      chk("ovr_valid1", 32'(v1), 32'd1);
      chk("ovr_flag1", 32'(ov1), 32'd0);
      chk("ovr_out1", {l1, r1}, 32'h1111_2222);
      send_frame(32'h3333, 16, 0, 32'h4444, 16, 0);
      tick(2);
      chk("ovr_valid2", 32'(v1), 32'd1);
      chk("ovr_flag2", 32'(ov1), 32'd1);
      chk("ovr_out2", {l1, r1}, 32'h3333_4444);
      clr = 1;
      tick(1);
      clr = 0;
      tick(1);
      chk("ovr_clear", 32'(ov1), 32'd0);
      chk("ovr_valid_kept", 32'(v1), 32'd1);
      rdy = 1;
      tick(2);
      chk("ovr_drain_valid", 32'(v1), 32'd0);
      chk_frame("ovr_drain", 32'h3333_4444);
      fork
         send_frame(32'hDEAD, 16, 0, 32'hBEEF, 16, 0);
         begin
            tick(16 * 6);
            en = 0;
         end
      join
      send_frame(32'h1212, 16, 0, 32'h3434, 16, 0);
      send_frame(32'h5656, 16, 0, 32'h7878, 16, 0);
      fork
         send_frame(32'h9A9A, 16, 0, 32'hBCBC, 16, 0);
         begin
            tick(17 * 16 + 16 * 4);
            en = 1;
         end
      join
      tick(2);
      chk("en_off_count", 32'(q1.size()), 32'd0);
      send_frame(32'h6543, 16, 0, 32'h789A, 16, 0);
      tick(2);
      chk_frame("en_resume", 32'h6543_789A);
      chk("en_overrun", 32'(ov1), 32'd0);
      dly = 0;
      rst = 1;
      tick(3);
      rst = 0;
      q0.delete();
      idle(4);
      send_frame(32'h8000, 16, 0, 32'h7FFF, 16, 0);
      tick(2);
      chk("lj_count", 32'(q0.size()), 32'd1);
      chk("lj_frame", (q0.size() > 0) ? q0[0] : 32'hxxxxxxxx, 32'h8000_7FFF);
      q0.delete();
      send_frame(32'hA5C3, 16, 0, 32'h1234, 16, 0);
      tick(2);
      chk("lj_count2", 32'(q0.size()), 32'd1);
      chk("lj_frame2", (q0.size() > 0) ? q0[0] : 32'hxxxxxxxx, 32'hA5C3_1234);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
